// File: rtl/ms_seq_ctrl.sv
// Sequencer and coefficient storage for the NTRU serial multiplier: loads h and r,
// walks the AU array over every (r_j, block) pair, then streams out e = r*h.
module ms_seq_ctrl #(
    parameter int unsigned N = 509,
    parameter int unsigned Q = 2048,
    parameter int unsigned P = 3,
    parameter int unsigned M = 1,
    localparam int unsigned W  = $clog2(Q - 1),
    localparam int unsigned RW = $clog2(P)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic           busy,
    output logic           done,
    output logic [RW-1:0]  au_r,
    output logic [M*W-1:0] au_h,
    output logic [M*W-1:0] au_e,
    input  logic [M*W-1:0] au_e_out
);

    localparam int unsigned B  = (N + M - 1) / M;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned IW = $clog2(B * M + 1);

    typedef enum logic [1:0] {LOAD_H, LOAD_R, MULT, OUT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] j, j_nxt;
    logic [KW-1:0] k, k_nxt;

    logic [W-1:0]  h_reg [N];
    logic [RW-1:0] r_reg [N];
    logic [W-1:0]  e_reg [N];

    logic          h_load, h_rot, r_load, e_wr, e_clr, mult_end;
    logic          s_fire, m_fire, cnt_last, j_last, k_last;
    logic [IW-1:0] lane_sum [M];
    logic [CW-1:0] lane_idx [M];
    logic          lane_ok  [M];

    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_ready && (state == OUT);
    assign cnt_last = (cnt == CW'(N - 1));
    assign j_last   = (j == CW'(N - 1));
    assign k_last   = (k == KW'(B - 1));

    // Coefficient index served by each AU lane in the current block
    always_comb begin
        for (int l = 0; l < M; l++) begin
            lane_sum[l] = IW'(k) * IW'(M) + IW'(l);
            lane_ok[l]  = lane_sum[l] < IW'(N);
            lane_idx[l] = CW'(lane_sum[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_H;
            cnt     <= '0;
            j       <= '0;
            k       <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            j       <= j_nxt;
            k       <= k_nxt;
            s_ready <= (state_nxt == LOAD_H) || (state_nxt == LOAD_R);
            busy    <= (state_nxt == MULT);
            m_valid <= (state_nxt == OUT);
            done    <= mult_end;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        j_nxt     = j;
        k_nxt     = k;
        h_load    = 1'b0;
        h_rot     = 1'b0;
        r_load    = 1'b0;
        e_wr      = 1'b0;
        e_clr     = 1'b0;
        mult_end  = 1'b0;
        unique case (state)
            LOAD_H: begin
                if (s_fire) begin
                    h_load = 1'b1;
                    if (cnt_last) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_R;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            LOAD_R: begin
                if (s_fire) begin
                    r_load = 1'b1;
                    if (cnt_last) begin
                        cnt_nxt   = '0;
                        j_nxt     = '0;
                        k_nxt     = '0;
                        state_nxt = MULT;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            MULT: begin
                e_wr = 1'b1;
                if (k_last) begin
                    // End of a row: rotate h so the next r_j sees h shifted by one
                    k_nxt = '0;
                    h_rot = 1'b1;
                    if (j_last) begin
                        j_nxt     = '0;
                        cnt_nxt   = '0;
                        mult_end  = 1'b1;
                        state_nxt = OUT;
                    end else begin
                        j_nxt = j + CW'(1);
                    end
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            OUT: begin
                if (m_fire) begin
                    if (cnt_last) begin
                        e_clr     = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = LOAD_H;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = LOAD_H;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) h_reg[i] <= '0;
        end else if (h_load) begin
            h_reg[cnt] <= s_data;
        end else if (h_rot) begin
            h_reg[0] <= h_reg[N-1];
            for (int i = 1; i < N; i++) h_reg[i] <= h_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_reg[i] <= '0;
        end else if (r_load) begin
            r_reg[cnt] <= s_data[RW-1:0];
        end
    end

    // Lanes past the last coefficient of a ragged block are never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) e_reg[i] <= '0;
        end else if (e_clr) begin
            for (int i = 0; i < N; i++) e_reg[i] <= '0;
        end else if (e_wr) begin
            for (int l = 0; l < M; l++) begin
                if (lane_ok[l]) e_reg[lane_idx[l]] <= au_e_out[l*W +: W];
            end
        end
    end

    always_comb begin
        au_r = '0;
        au_h = '0;
        au_e = '0;
        if (state == MULT) begin
            au_r = r_reg[j];
            for (int l = 0; l < M; l++) begin
                if (lane_ok[l]) begin
                    au_h[l*W +: W] = h_reg[lane_idx[l]];
                    au_e[l*W +: W] = e_reg[lane_idx[l]];
                end
            end
        end
    end

    assign m_data = (state == OUT) ? e_reg[cnt] : '0;
    assign m_last = (state == OUT) && cnt_last;

endmodule
